rv32i_multicycle_control: RTL and testbench
===========================================

Name: rv32i_multicycle_control

Overview:
- Parametrised main controller for the multicycle RV32I core.
- Decodes the latched instruction (IR) and sequences the shared datapath: PC/PC_old regs, A/B regs, ALU, alu_last reg, mem_data reg, result mux.
- Over the previous controller it adds: memory ready/wait-state handshake with timeout, all six branch conditions, jalr/lui/auipc, an ena stall, a sticky error flag and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 0, max wait cycles for mem_ready per access; 0 = wait forever.
RETIRE_W, 32, width of retired-instruction counter.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ena  input  1  0 = stall: state frozen, all write strobes forced 0
instr  input  32  IR contents
equal  input  1  reg_A == reg_B
lt  input  1  signed reg_A < reg_B
ltu  input  1  unsigned reg_A < reg_B
mem_ready  input  1  memory access completes this cycle
mem_req  output  1  memory access active
mem_wr_ena  output  1  store strobe
adr_src  output  1  0=PC, 1=result
ir_write  output  1  latch IR
pc_write  output  1  load PC (and PC_old)
alu_src_a  output  2  0=PC, 1=PC_old, 2=reg_A, 3=zero
alu_src_b  output  2  0=reg_B, 1=imm_ext, 2=const 4
alu_control  output  alu_control_t  ALU op
result_src  output  2  0=alu_result, 1=mem_data, 2=alu_last
reg_write  output  1  register-file write
error  output  1  sticky; high in S_ERROR
retired  output  RETIRE_W  count of completed instructions

Behaviour:
- Reset (clk edge with rst=1): state=S_FETCH, wait counter=0, retired=0, error=0.
- Output defaults, applied in every state unless the state says otherwise:
  - strobes 0
  - adr_src=0, alu_src_a=0, alu_src_b=2
  - alu_control=ALU_ADD, result_src=0
- States and transitions:
  - S_FETCH: mem_req=1, adr_src=0, PC+4 on ALU, result_src=0. On mem_ready: ir_write=1, pc_write=1, go to S_DECODE. Otherwise hold.
  - S_DECODE: PC_old+imm_ext (branch/jal target) into alu_last. Next state by opcode:
    - load/store -> S_MEMADR
    - R -> S_EXECUTER
    - I-ALU -> S_EXECUTEI
    - jal -> S_JAL
    - jalr -> S_JALR
    - branch -> S_BRANCH
    - lui -> S_LUI
    - auipc -> S_AUIPC
    - any other opcode -> S_ERROR
  - S_MEMADR: reg_A+imm. Next is S_MEMWRITE if instr[5]=1, else S_MEMREAD.
  - S_MEMREAD: mem_req=1, adr_src=1, result_src=2. On mem_ready go to S_MEMWB.
  - S_MEMWB: result_src=1, reg_write=1, go to S_FETCH.
  - S_MEMWRITE: mem_req=1, mem_wr_ena=1, adr_src=1, result_src=2. On mem_ready go to S_FETCH.
  - S_EXECUTER: reg_A op reg_B. S_EXECUTEI: reg_A op imm. Both go to S_ALUWB.
  - S_ALUWB: result_src=2, reg_write=1, go to S_FETCH.
  - S_JAL: pc_write=1 with result_src=2; ALU computes PC_old+4. Go to S_ALUWB.
  - S_JALR: reg_A+imm, result_src=0, pc_write=1; the datapath clears bit0. Go to S_JALR_LINK.
  - S_JALR_LINK: PC_old+4 into alu_last, go to S_ALUWB.
  - S_BRANCH: alu_control=ALU_SUB on reg_A/reg_B. Taken by funct3:
    - 000 equal
    - 001 !equal
    - 100 lt
    - 101 !lt
    - 110 ltu
    - 111 !ltu
    - If taken: pc_write=1, result_src=2. Go to S_FETCH.
    - funct3 010/011 -> S_ERROR.
  - S_LUI: src_a=3, src_b=1 -> S_ALUWB.
  - S_AUIPC: src_a=1, src_b=1 -> S_ALUWB.
  - S_ERROR: all strobes 0, error=1, stays there until rst.
- ALU decode (S_EXECUTER/S_EXECUTEI), funct3 mapping:
  - 000: ALU_SUB if R-type and funct7[5], else ALU_ADD
  - 001 ALU_SLL, 010 ALU_SLT, 011 ALU_SLTU, 100 ALU_XOR, 110 ALU_OR, 111 ALU_AND
  - 101: ALU_SRA if funct7[5], else ALU_SRL (applies to R and I)
- Wait counter:
  - Counts cycles in a mem_req state with mem_ready=0; clears on leaving the state.
  - With MEM_TIMEOUT>0, reaching MEM_TIMEOUT goes to S_ERROR on the next edge.
  - mem_ready in the same cycle as the limit wins.
- retired increments by 1 on each transition into S_FETCH from a state other than S_FETCH. Wraps modulo 2^RETIRE_W.
- ena=0:
  - state, wait counter and retired hold.
  - mem_req, mem_wr_ena, ir_write, pc_write and reg_write are all 0.
  - mem_ready is ignored.
- rst has priority over ena and over an in-flight access. Reset during a wait state aborts it (no strobe the next cycle).

Test Plan:
- addi x1,x0,5 with mem_ready tied 1 -> 4 cycles FETCH,DECODE,EXECUTEI,ALUWB; reg_write=1 with result_src=2 in cycle 4; retired=1.
- Fetch with mem_ready low for 3 cycles -> mem_req=1 and ir_write=0 for 3 cycles, ir_write=pc_write=1 only in the 4th; with MEM_TIMEOUT=2 instead -> error=1, state S_ERROR, no strobes after.
- bne with equal=0 -> pc_write=1, result_src=2 in S_BRANCH; with equal=1 -> pc_write=0; funct3=010 -> error=1.
- jalr x1,0(x2) -> S_JALR pc_write=1 (src_a=2, src_b=1), then JALR_LINK, ALUWB with reg_write=1.
- sw with mem_ready low 2 cycles and ena dropped 1 cycle mid-wait -> mem_wr_ena=0 during the stall, state held; completes on ready; retired +1.
- rst pulsed during S_MEMREAD wait -> next cycle state S_FETCH, retired=0, mem_wr_ena=0, reg_write=0.

Source files
------------

// File: rtl/rv32i_multicycle_control.sv
// Main controller for the multicycle RV32I core: decodes IR and sequences the shared datapath,
// with memory wait/timeout handling, ena stall, sticky error state and retired counter.
module rv32i_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ena_i,
    input  logic [31:0]         instr_i,
    input  logic                equal_i,
    input  logic                lt_i,
    input  logic                ltu_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_wr_ena_o,
    output logic                adr_src_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic [1:0]          alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [3:0]          alu_control_o,
    output logic [1:0]          result_src_o,
    output logic                reg_write_o,
    output logic                error_o,
    output logic [RETIRE_W-1:0] retired_o
);

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSlt  = 4'd5;
    localparam logic [3:0] AluSltu = 4'd6;
    localparam logic [3:0] AluSll  = 4'd7;
    localparam logic [3:0] AluSrl  = 4'd8;
    localparam logic [3:0] AluSra  = 4'd9;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StJal, StJalr, StJalrLink, StBranch, StLui, StAuipc, StError
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         wait_q, wait_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [3:0] alu_op;
    logic       mem_state;
    logic       taken;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign funct7_b5    = instr_i[30];
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    always_comb begin
        unique case (funct3)
            3'b000:  alu_op = (opcode == OpR && funct7_b5) ? AluSub : AluAdd;
            3'b001:  alu_op = AluSll;
            3'b010:  alu_op = AluSlt;
            3'b011:  alu_op = AluSltu;
            3'b100:  alu_op = AluXor;
            3'b101:  alu_op = funct7_b5 ? AluSra : AluSrl;
            3'b110:  alu_op = AluOr;
            default: alu_op = AluAnd;
        endcase
    end

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);

    always_comb begin
        state_d       = state_q;
        mem_req_o     = 1'b0;
        mem_wr_ena_o  = 1'b0;
        adr_src_o     = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        alu_src_a_o   = 2'd0;
        alu_src_b_o   = 2'd2;
        alu_control_o = AluAdd;
        result_src_o  = 2'd0;
        reg_write_o   = 1'b0;
        taken         = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpBranch:        state_d = StBranch;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StError;
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                state_d     = instr_i[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req_o    = 1'b1;
                adr_src_o    = 1'b1;
                result_src_o = 2'd2;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                result_src_o = 2'd1;
                reg_write_o  = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                mem_req_o    = 1'b1;
                mem_wr_ena_o = 1'b1;
                adr_src_o    = 1'b1;
                result_src_o = 2'd2;
                if (mem_ready_i) state_d = StFetch;
            end
            StExecR: begin
                alu_src_a_o   = 2'd2;
                alu_src_b_o   = 2'd0;
                alu_control_o = alu_op;
                state_d       = StAluWb;
            end
            StExecI: begin
                alu_src_a_o   = 2'd2;
                alu_src_b_o   = 2'd1;
                alu_control_o = alu_op;
                state_d       = StAluWb;
            end
            StAluWb: begin
                result_src_o = 2'd2;
                reg_write_o  = 1'b1;
                state_d      = StFetch;
            end
            StJal: begin
                alu_src_a_o  = 2'd1;
                pc_write_o   = 1'b1;
                result_src_o = 2'd2;
                state_d      = StAluWb;
            end
            StJalr: begin
                alu_src_a_o = 2'd2;
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                state_d     = StJalrLink;
            end
            StJalrLink: begin
                alu_src_a_o = 2'd1;
                state_d     = StAluWb;
            end
            StBranch: begin
                alu_src_a_o   = 2'd2;
                alu_src_b_o   = 2'd0;
                alu_control_o = AluSub;
                state_d       = StFetch;
                case (funct3)
                    3'b000:  taken = equal_i;
                    3'b001:  taken = !equal_i;
                    3'b100:  taken = lt_i;
                    3'b101:  taken = !lt_i;
                    3'b110:  taken = ltu_i;
                    3'b111:  taken = !ltu_i;
                    default: state_d = StError;
                endcase
                if (taken) begin
                    pc_write_o   = 1'b1;
                    result_src_o = 2'd2;
                end
            end
            StLui: begin
                alu_src_a_o = 2'd3;
                alu_src_b_o = 2'd1;
                state_d     = StAluWb;
            end
            StAuipc: begin
                alu_src_a_o = 2'd1;
                alu_src_b_o = 2'd1;
                state_d     = StAluWb;
            end
            default: state_d = StError;
        endcase

        // A ready arriving in the limit cycle completes the access instead of timing out.
        if (MEM_TIMEOUT != 0 && mem_state && !mem_ready_i && wait_q == 32'(MEM_TIMEOUT)) begin
            state_d = StError;
        end

        if (!ena_i) begin
            mem_req_o    = 1'b0;
            mem_wr_ena_o = 1'b0;
            ir_write_o   = 1'b0;
            pc_write_o   = 1'b0;
            reg_write_o  = 1'b0;
        end
    end

    always_comb begin
        wait_d    = (mem_state && !mem_ready_i) ? wait_q + 32'd1 : 32'd0;
        retired_d = retired_q;
        if (state_q != StFetch && state_d == StFetch) retired_d = retired_q + RETIRE_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            wait_q    <= 32'd0;
            retired_q <= '0;
        end else if (ena_i) begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    assign error_o   = (state_q == StError);
    assign retired_o = retired_q;

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Bench for rv32i_multicycle_control: per-instruction expected cycle traces built from the
// instruction class, replayed with random memory waits, stalls and branch flags.
module tb_rv32i_multicycle_control;

    localparam int unsigned TO = 3;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;

    logic        clk = 1'b0, rst = 1'b1, ena = 1'b1, mem_ready = 1'b0;
    logic        equal = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        mem_req, mem_wr_ena, adr_src, ir_write, pc_write, reg_write, error;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control;
    logic [31:0] retired;

    rv32i_multicycle_control #(.MEM_TIMEOUT(TO), .RETIRE_W(32)) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .instr_i(instr), .equal_i(equal), .lt_i(lt),
        .ltu_i(ltu), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_wr_ena_o(mem_wr_ena),
        .adr_src_o(adr_src), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_control_o(alu_control),
        .result_src_o(result_src), .reg_write_o(reg_write), .error_o(error),
        .retired_o(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_wr;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu;
        logic [1:0] rsrc;
        logic       reg_write;
    } out_t;

    typedef struct packed {
        out_t        o;
        logic        ena;
        logic        ready;
        logic        last;
        logic        err;
        logic [31:0] ins;
        logic        eq;
        logic        lt;
        logic        ltu;
    } rec_t;

    rec_t        trace[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ret_m = 32'd0;
    bit          stalls_on = 1'b0;
    logic [31:0] cur_ins;
    logic        cur_eq, cur_lt, cur_ltu;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t dflt();
        out_t o = '0;
        o.src_b = 2'd2;
        o.alu   = A_ADD;
        return o;
    endfunction

    function automatic rec_t mk(input out_t o, input logic last, input logic err);
        rec_t r;
        r.o = o; r.ena = 1'b1; r.ready = 1'($urandom_range(0, 1)); r.last = last; r.err = err;
        r.ins = cur_ins; r.eq = cur_eq; r.lt = cur_lt; r.ltu = cur_ltu;
        return r;
    endfunction

    // A stalled cycle shows the same datapath selects with every strobe suppressed.
    function automatic rec_t stalled(input rec_t r);
        rec_t s = r;
        s.ena = 1'b0; s.last = 1'b0; s.ready = 1'($urandom_range(0, 1));
        s.o.mem_req = 1'b0; s.o.mem_wr = 1'b0; s.o.ir_write = 1'b0;
        s.o.pc_write = 1'b0; s.o.reg_write = 1'b0;
        return s;
    endfunction

    task automatic add(input rec_t r);
        if (stalls_on && $urandom_range(0, 7) == 0) trace.push_back(stalled(r));
        trace.push_back(r);
    endtask

    task automatic add_mem(input out_t ow, input out_t od, input int waits, input logic last);
        rec_t r;
        for (int i = 0; i < waits; i++) begin
            r = mk(ow, 1'b0, 1'b0); r.ready = 1'b0; add(r);
        end
        r = mk(od, last, 1'b0); r.ready = 1'b1; add(r);
    endtask

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic b30, input logic is_r);
        case (f3)
            3'd0: return (is_r && b30) ? A_SUB : A_ADD;
            3'd1: return A_SLL;
            3'd2: return A_SLT;
            3'd3: return A_SLTU;
            3'd4: return A_XOR;
            3'd5: return b30 ? A_SRA : A_SRL;
            3'd6: return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic e, input logic l,
                                      input logic lu);
        case (f3)
            3'd0: return e;
            3'd1: return !e;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            default: return !lu;
        endcase
    endfunction

    task automatic err_tail();
        add(mk(dflt(), 1'b0, 1'b1));
        add(mk(dflt(), 1'b0, 1'b1));
    endtask

    task automatic alu_wb();
        out_t o = dflt();
        o.rsrc = 2'd2; o.reg_write = 1'b1;
        add(mk(o, 1'b1, 1'b0));
    endtask

    // Expected cycle-by-cycle trace of one instruction, derived from its class.
    task automatic build(input logic [31:0] ins, input int wf, input int wm, input logic e,
                         input logic l, input logic lu);
        out_t o, od;
        logic [2:0] f3 = ins[14:12];
        cur_ins = ins; cur_eq = e; cur_lt = l; cur_ltu = lu;
        o = dflt(); o.mem_req = 1'b1;
        od = o; od.ir_write = 1'b1; od.pc_write = 1'b1;
        add_mem(o, od, wf, 1'b0);
        o = dflt(); o.src_a = 2'd1; o.src_b = 2'd1;
        add(mk(o, 1'b0, 1'b0));
        o = dflt();
        case (ins[6:0])
            7'b0000011, 7'b0100011: begin
                o.src_a = 2'd2; o.src_b = 2'd1;
                add(mk(o, 1'b0, 1'b0));
                o = dflt(); o.mem_req = 1'b1; o.adr_src = 1'b1; o.rsrc = 2'd2;
                o.mem_wr = ins[5];
                add_mem(o, o, wm, ins[5]);
                if (!ins[5]) begin
                    o = dflt(); o.rsrc = 2'd1; o.reg_write = 1'b1;
                    add(mk(o, 1'b1, 1'b0));
                end
            end
            7'b0110011: begin
                o.src_a = 2'd2; o.src_b = 2'd0; o.alu = alu_ref(f3, ins[30], 1'b1);
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            7'b0010011: begin
                o.src_a = 2'd2; o.src_b = 2'd1; o.alu = alu_ref(f3, ins[30], 1'b0);
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            7'b1101111: begin
                o.src_a = 2'd1; o.pc_write = 1'b1; o.rsrc = 2'd2;
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            7'b1100111: begin
                o.src_a = 2'd2; o.src_b = 2'd1; o.pc_write = 1'b1;
                add(mk(o, 1'b0, 1'b0));
                o = dflt(); o.src_a = 2'd1;
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            7'b1100011: begin
                o.src_a = 2'd2; o.src_b = 2'd0; o.alu = A_SUB;
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    add(mk(o, 1'b0, 1'b0)); err_tail();
                end else begin
                    if (br_taken(f3, e, l, lu)) begin
                        o.pc_write = 1'b1; o.rsrc = 2'd2;
                    end
                    add(mk(o, 1'b1, 1'b0));
                end
            end
            7'b0110111: begin
                o.src_a = 2'd3; o.src_b = 2'd1;
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            7'b0010111: begin
                o.src_a = 2'd1; o.src_b = 2'd1;
                add(mk(o, 1'b0, 1'b0)); alu_wb();
            end
            default: err_tail();
        endcase
    endtask

    task automatic run();
        rec_t r;
        out_t obs;
        while (trace.size() > 0) begin
            r = trace.pop_front();
            @(negedge clk);
            rst = 1'b0; ena = r.ena; mem_ready = r.ready;
            instr = r.ins; equal = r.eq; lt = r.lt; ltu = r.ltu;
            #1;
            obs.mem_req = mem_req; obs.mem_wr = mem_wr_ena; obs.adr_src = adr_src;
            obs.ir_write = ir_write; obs.pc_write = pc_write; obs.src_a = alu_src_a;
            obs.src_b = alu_src_b; obs.alu = alu_control; obs.rsrc = result_src;
            obs.reg_write = reg_write;
            chk("outputs", 32'(obs), 32'(r.o));
            chk("retired", retired, ret_m);
            chk("error", 32'(error), 32'(r.err));
            @(posedge clk);
            if (r.ena && r.last) ret_m++;
        end
    endtask

    task automatic do_reset(input logic ena_val);
        @(negedge clk);
        rst = 1'b1; ena = ena_val; mem_ready = 1'b0;
        @(posedge clk);
        ret_m = 32'd0;
        #1;
        chk("reset_retired", retired, 32'd0);
        chk("reset_error", 32'(error), 32'd0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [6:0]  ops[9];
        logic [2:0]  bf3[6];
        rec_t        r;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0110111, 7'b0010111};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        do_reset(1'b1);
        build(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0);    // addi x1,x0,5
        run();
        #1 chk("addi_retired", retired, 32'd1);
        build(32'h00500093, 3, 0, 1'b0, 1'b0, 1'b0);    // three fetch wait cycles
        run();
        build(32'h00209463, 0, 0, 1'b0, 1'b0, 1'b0);    // bne taken
        run();
        build(32'h00209463, 0, 0, 1'b1, 1'b0, 1'b0);    // bne not taken
        run();
        build(32'h0020A463, 0, 0, 1'b0, 1'b0, 1'b0);    // branch funct3=010
        run();
        do_reset(1'b1);
        build(32'h000100E7, 0, 0, 1'b0, 1'b0, 1'b0);    // jalr x1,0(x2)
        run();
        build(32'h00112023, 0, 2, 1'b0, 1'b0, 1'b0);    // sw, stall mid-wait
        r = stalled(trace[3]); r.ready = 1'b1;
        trace.insert(4, r);
        run();
        build(32'h00012083, 0, 3, 1'b0, 1'b0, 1'b0);    // lw, cut inside the read wait
        while (trace.size() > 4) void'(trace.pop_back());
        run();
        do_reset(1'b0);
        build(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0);
        run();
        build(32'h0000007F, 0, 0, 1'b0, 1'b0, 1'b0);    // illegal opcode
        run();
        do_reset(1'b1);

        // Fetch that never completes: TO+1 waiting cycles, then the error state.
        cur_ins = 32'h00500093;
        for (int i = 0; i <= int'(TO); i++) begin
            out_t o = dflt();
            o.mem_req = 1'b1;
            r = mk(o, 1'b0, 1'b0); r.ready = 1'b0;
            trace.push_back(r);
        end
        err_tail();
        run();
        do_reset(1'b1);

        stalls_on = 1'b1;
        for (int n = 0; n < 200; n++) begin
            int cls = int'($urandom_range(0, 8));
            ins = $urandom;
            ins[6:0] = ops[cls];
            if (cls == 6) ins[14:12] = bf3[$urandom_range(0, 5)];
            build(ins, int'($urandom_range(0, TO)), int'($urandom_range(0, TO)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run();
        end
        #1 chk("final_retired", retired, ret_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
